mant_mul_seq: RTL
=================

Name: mant_mul_seq

Overview:
Iterative radix-2 shift-and-add multiplier for 24-bit unsigned mantissas (hidden bit included), producing the full 48-bit product. It is the stage directly upstream of the FP normaliser/rounder. It also wraps the existing 48-bit carry-lookahead adder, which it uses as the accumulator adder each iteration. It trades area for latency: one multiplier bit per clock, with a valid/ready handshake on both sides.

Parameters:
WIDTH, 24, operand width; must be 24 (elaboration-time check) because the accumulator adder is fixed at 48 bits.
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
i_clk      input   1        clock, all state on rising edge
i_reset    input   1        synchronous, active-high reset
i_flush    input   1        synchronous abort of any in-flight operation
i_valid    input   1        operands valid
o_ready    output  1        block can accept operands (high only in IDLE)
i_a        input   WIDTH    multiplicand, unsigned
i_b        input   WIDTH    multiplier, unsigned
o_valid    output  1        product valid
i_ready    input   1        downstream accepts product
o_product  output  2*WIDTH  i_a * i_b, unsigned
o_busy     output  1        high in CALC or DONE

Behaviour:
- States: IDLE, CALC, DONE. Encoding is binary and comes from the shared package.
- Reset (i_reset=1 at an edge): state=IDLE, accumulator=0, o_product=0, o_valid=0, counter=0, internal shift regs=0. o_ready reads 1 from the first cycle after reset and is forced 0 while i_reset=1.
- o_ready = (state==IDLE). o_valid = (state==DONE). o_busy = (state!=IDLE). All three are decoded from registered state only; there is no combinational path from i_valid or i_ready.
- IDLE: on i_valid && o_ready:
  - mcand <= {24'b0, i_a}, mplier <= i_b, acc <= 0, cnt <= 0.
  - Go to CALC.
  - The operands are sampled only at this edge; later changes to i_a/i_b are ignored.
- CALC, each cycle:
  - If mplier[0]=1, acc <= acc + mcand via the 48-bit CLA (C_in=0); otherwise acc holds.
  - mcand <= mcand << 1, mplier <= mplier >> 1, cnt <= cnt + 1.
  - When cnt==WIDTH-1, the update still happens and the state moves to DONE.
- Latency: exactly WIDTH+1 = 25 cycles from the accept edge to the first cycle o_valid=1. No early termination, so the latency does not depend on the data.
- CLA carry-out must be 0 on every iteration, because the product cannot exceed 48 bits. A simulation assertion flags any violation.
- DONE:
  - o_product = acc, held stable while o_valid=1 && i_ready=0 (unbounded backpressure).
  - On i_ready=1, go to IDLE. o_product keeps its last value; it is only meaningful while o_valid=1.
- o_ready is 0 in DONE, so a new operation cannot be accepted in the same cycle as the handoff. The minimum issue interval is 26 cycles.
- i_flush=1 at an edge, in any state: go to IDLE, o_valid=0, partial result discarded. If i_flush and i_valid arrive in the same IDLE cycle, the flush wins and nothing is accepted.
- i_reset has priority over i_flush. Reset mid-CALC or mid-DONE behaves exactly like reset from IDLE.
- i_ready is ignored outside DONE. i_valid is ignored outside IDLE.
- Zero operands still take the full 25 cycles and produce 0.

Decomposition:
- Package fp_mul_pkg:
  - mul_state_e enum (IDLE, CALC, DONE).
  - MANT_W=24 and PROD_W=48 localparams.
  - prod_t typedef (logic [47:0]).
- Sub-module: the existing cla_48bit is instantiated once as the accumulator adder (A=acc, B=mcand, C_in=0).
- Counter, shift registers and FSM stay in a single module.

Test Plan:
1. Reset, then i_a=0xFFFFFF, i_b=0xFFFFFF with i_ready=1 -> o_valid rises exactly 25 cycles after accept; o_product=0xFFFFFE000001; o_ready returns 1 the next cycle.
2. i_a=0x800000, i_b=0x800000 -> 0x400000000000. Then i_a=0x000001, i_b=0xABCDEF -> 0x000000ABCDEF. Then i_a=0, i_b=0x123456 -> 0, still 25-cycle latency.
3. Backpressure: i_a=0xC00000, i_b=0xA00000 with i_ready=0 for 10 cycles after o_valid -> o_product=0x780000000000 stable and o_valid held for all 10 cycles; i_valid pulses in that window are not accepted.
4. Flush: assert i_flush 10 cycles into CALC -> IDLE next cycle, o_valid never rises. A following op 0x000003*0x000005 returns 0x00000000000F.
5. Reset mid-op: i_reset high during CALC cycle 12 -> o_valid=0, o_product=0, o_ready=1 after release; no stale product ever appears.
6. Back-to-back: 200 random operand pairs with i_valid held high and random i_ready -> every product matches the reference a*b; no CLA carry-out assertion fires; issue interval ≥26 cycles.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types for the FP multiplier datapath: mantissa/product widths and
// the sequential mantissa multiplier state encoding.
package fp_mul_pkg;

  localparam int MANT_W = 24;
  localparam int PROD_W = 48;

  typedef logic [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/cla_48bit.sv
// 48-bit carry-lookahead adder: 4-bit lookahead groups whose group
// generate/propagate terms are chained to form the inter-group carries.
module cla_48bit (
  input  logic [47:0] a,
  input  logic [47:0] b,
  input  logic        c_in,
  output logic [47:0] sum,
  output logic        c_out
);

  localparam int GROUPS = 12;

  logic [47:0]     gen;
  logic [47:0]     prop;
  logic [47:0]     carry;
  logic [11:0]     grp_gen;
  logic [11:0]     grp_prop;
  logic [GROUPS:0] grp_c;

  always_comb begin
    gen      = a & b;
    prop     = a ^ b;
    carry    = '0;
    grp_gen  = '0;
    grp_prop = '0;
    grp_c    = '0;
    grp_c[0] = c_in;
    for (int k = 0; k < GROUPS; k++) begin
      carry[4*k]   = grp_c[k];
      carry[4*k+1] = gen[4*k] | (prop[4*k] & grp_c[k]);
      carry[4*k+2] = gen[4*k+1]
                   | (prop[4*k+1] & gen[4*k])
                   | (prop[4*k+1] & prop[4*k] & grp_c[k]);
      carry[4*k+3] = gen[4*k+2]
                   | (prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                   | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & grp_c[k]);
      grp_gen[k]   = gen[4*k+3]
                   | (prop[4*k+3] & gen[4*k+2])
                   | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      grp_prop[k]  = &prop[4*k +: 4];
      grp_c[k+1]   = grp_gen[k] | (grp_prop[k] & grp_c[k]);
    end
    sum   = prop ^ carry;
    c_out = grp_c[GROUPS];
  end

endmodule

// File: rtl/mant_mul_seq.sv
// Radix-2 shift-and-add mantissa multiplier: one multiplier bit per clock,
// accumulating through the shared 48-bit CLA, valid/ready on both sides.
module mant_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_busy
);

  // The accumulator adder is a fixed 48-bit macro, so only 24-bit operands fit.
  if (WIDTH != MANT_W) begin : g_bad_width
    $error("mant_mul_seq: WIDTH must be %0d", MANT_W);
  end
  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
    $error("mant_mul_seq: CNT_W too narrow for WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e state_q;
  mul_state_e state_d;

  prod_t            acc_q;
  prod_t            mcand_q;
  prod_t            product_q;
  prod_t            acc_next;
  prod_t            cla_sum;
  logic             cla_cout;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_iter;

  cla_48bit u_acc_adder (
    .a     (acc_q),
    .b     (mcand_q),
    .c_in  (1'b0),
    .sum   (cla_sum),
    .c_out (cla_cout)
  );

  assign last_iter = (cnt_q == LAST_CNT);
  assign acc_next  = mplier_q[0] ? cla_sum : acc_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush overrides every transition, including an accept in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)   state_d = CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (i_ready)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (i_flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (!i_flush) begin
      if (state_q == IDLE && i_valid) begin
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, i_a};
        mplier_q <= i_b;
        cnt_q    <= '0;
      end else if (state_q == CALC) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (last_iter) begin
          product_q <= acc_next;
        end
      end
    end
  end

  // A full-width product can never overflow 48 bits, so a carry-out is a bug.
  always_ff @(posedge i_clk) begin
    if (!i_reset && state_q == CALC && mplier_q[0]) begin
      assert (!cla_cout)
        else $error("mant_mul_seq: accumulator carry-out during accumulate");
    end
  end

  assign o_ready   = (state_q == IDLE) && !i_reset;
  assign o_valid   = (state_q == DONE);
  assign o_busy    = (state_q != IDLE);
  assign o_product = product_q;

endmodule
